nim_coincidence_trigger: RTL

//   Downstream of the per-channel NIM input conditioners (invert/stretch/delay). Takes the

---
 rtl/nim_trig_pkg.sv | 12 +
 rtl/nim_sat_counter.sv | 14 +
 rtl/nim_coincidence_trigger.sv | 88 ++++++++
 3 files changed

// File: rtl/nim_trig_pkg.sv
// nim_trig_pkg: shared state enum, default widths and popcount for the NIM coincidence trigger
package nim_trig_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, DEAD} trig_state_t;
  localparam int N_CH_DEF = 4;
  localparam int PW_W_DEF = 16;
  localparam int DT_W_DEF = 16;
  localparam int CNT_W_DEF = 32;
  function automatic logic [4:0] popcount(input logic [15:0] v);
    popcount = '0;
    for (int i = 0; i < 16; i++) popcount = popcount + 5'(v[i]);
  endfunction
endpackage

// File: rtl/nim_sat_counter.sv
// nim_sat_counter: saturating up-counter, clear wins over a same-cycle increment
module nim_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset || clr) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/nim_coincidence_trigger.sv
// nim_coincidence_trigger: masked majority coincidence -> fixed-width pulse with deadtime, veto, counters.
// Define NIM_TRIG_PRESCALE_EN to fire only on every (prescale+1)-th acceptable candidate.
module nim_coincidence_trigger
  import nim_trig_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int PW_W  = PW_W_DEF,
  parameter int DT_W  = DT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_CH-1:0]            ch_in,
  input  logic [N_CH-1:0]            ch_mask,
  input  logic [$clog2(N_CH+1)-1:0]  majority,
  input  logic [PW_W-1:0]            out_width,
  input  logic [DT_W-1:0]            deadtime,
  input  logic                       veto_in,
  input  logic [15:0]                prescale,
  input  logic                       count_clear,
  output logic                       trig_out,
  output logic                       busy,
  output logic [CNT_W-1:0]           trig_count,
  output logic [CNT_W-1:0]           reject_count
);
  localparam int CW = (PW_W > DT_W) ? PW_W : DT_W;
  trig_state_t state;
  logic [CW-1:0] cnt;
  logic coin, coin_prev, candidate, accept_ok, fire;
  assign coin = (popcount(16'(ch_in & ch_mask)) >= 5'(majority)) && (majority != '0);
  assign candidate = coin && !coin_prev;
  assign accept_ok = candidate && (state == IDLE) && enable && !veto_in;
`ifdef NIM_TRIG_PRESCALE_EN
  logic [15:0] psc;
  assign fire = accept_ok && (psc == prescale);
  always_ff @(posedge clk)
    if (reset || count_clear) psc <= '0;
    else if (accept_ok) psc <= fire ? '0 : psc + 16'd1;
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign fire = accept_ok;
`endif
  // cnt is shared: holds remaining pulse cycles in PULSE, remaining idle cycles in DEAD
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      trig_out  <= 1'b0;
      busy      <= 1'b0;
      coin_prev <= 1'b0;
    end else begin
      coin_prev <= coin;
      case (state)
        IDLE:
          if (fire) begin
            state    <= PULSE;
            cnt      <= (out_width == '0) ? CW'(1) : CW'(out_width);
            trig_out <= 1'b1;
            busy     <= 1'b1;
          end
        PULSE:
          if (cnt <= CW'(1)) begin
            state    <= (deadtime != '0) ? DEAD : IDLE;
            cnt      <= CW'(deadtime);
            trig_out <= 1'b0;
            busy     <= (deadtime != '0);
          end else cnt <= cnt - CW'(1);
        DEAD:
          if (cnt <= CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else cnt <= cnt - CW'(1);
        default: begin
          state    <= IDLE;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  nim_sat_counter #(.W(CNT_W)) u_trig_cnt (
    .clk(clk), .reset(reset), .inc(fire), .clr(count_clear), .count(trig_count)
  );
  nim_sat_counter #(.W(CNT_W)) u_reject_cnt (
    .clk(clk), .reset(reset), .inc(candidate && !accept_ok), .clr(count_clear), .count(reject_count)
  );
endmodule
